// File: rtl/tx_arbiter_if.sv
// Bundle of the requester-side and core-side TLP transmit signals shared by tx_arbiter.
// A requester raises tx_req and holds it; a beat moves when tx_st/tx_end is presented while tx_rdy is high.
interface tx_arbiter_if;
    logic        r0_tx_req;
    logic        r0_tx_rdy;
    logic        r0_tx_st;
    logic        r0_tx_end;
    logic [15:0] r0_tx_data;
    logic        r1_tx_req;
    logic        r1_tx_rdy;
    logic        r1_tx_st;
    logic        r1_tx_end;
    logic [15:0] r1_tx_data;
    logic        tx_req;
    logic        tx_rdy;
    logic        tx_st;
    logic        tx_end;
    logic [15:0] tx_data;

    modport master (
        input  r0_tx_req, r0_tx_st, r0_tx_end, r0_tx_data,
        input  r1_tx_req, r1_tx_st, r1_tx_end, r1_tx_data,
        input  tx_rdy,
        output r0_tx_rdy, r1_tx_rdy,
        output tx_req, tx_st, tx_end, tx_data
    );

    modport slave (
        output r0_tx_req, r0_tx_st, r0_tx_end, r0_tx_data,
        output r1_tx_req, r1_tx_st, r1_tx_end, r1_tx_data,
        output tx_rdy,
        input  r0_tx_rdy, r1_tx_rdy,
        input  tx_req, tx_st, tx_end, tx_data
    );
endinterface

// File: rtl/tx_arbiter.sv
// Two-requester arbiter in front of a PCIe core transmit port: one whole TLP per grant,
// with a one-cycle GAP and re-arbitration between packets.
module tx_arbiter #(
    parameter bit PRIO0 = 1'b0
) (
    input  logic          clk_125,
    input  logic          sys_rst_n,
    tx_arbiter_if.master  bus,
    output logic [1:0]    grant,
    output logic          busy,
    output logic [15:0]   pkt_cnt0,
    output logic [15:0]   pkt_cnt1,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t      cur;
    state_t      nxt;
    logic [1:0]  grant_nxt;
    logic        last;
    logic        last_nxt;
    logic        pick;
    logic        done;
    logic        drive;
    logic        g_req;
    logic        g_st;
    logic        g_end;
    logic [15:0] g_data;

    always_comb begin
        g_req  = 1'b0;
        g_st   = 1'b0;
        g_end  = 1'b0;
        g_data = '0;
        if (grant[1]) begin
            g_req  = bus.r1_tx_req;
            g_st   = bus.r1_tx_st;
            g_end  = bus.r1_tx_end;
            g_data = bus.r1_tx_data;
        end else if (grant[0]) begin
            g_req  = bus.r0_tx_req;
            g_st   = bus.r0_tx_st;
            g_end  = bus.r0_tx_end;
            g_data = bus.r0_tx_data;
        end
    end

    // Core-facing signals are only live while a packet is being requested or moved.
    assign drive         = (cur == REQ) || (cur == XFER);
    assign bus.tx_req    = drive & g_req;
    assign bus.tx_st     = drive & g_st;
    assign bus.tx_end    = drive & g_end;
    assign bus.tx_data   = drive ? g_data : 16'h0000;
    assign bus.r0_tx_rdy = grant[0] & bus.tx_rdy;
    assign bus.r1_tx_rdy = grant[1] & bus.tx_rdy;

    // On a tie, last == 1 means requester 1 had the previous turn, so requester 0 goes next.
    assign pick = (bus.r0_tx_req & bus.r1_tx_req) ? (PRIO0 ? 1'b0 : ~last) : ~bus.r0_tx_req;

    always_comb begin
        nxt       = cur;
        grant_nxt = grant;
        last_nxt  = last;
        done      = 1'b0;
        case (cur)
            IDLE: begin
                if (bus.r0_tx_req || bus.r1_tx_req) begin
                    nxt       = REQ;
                    grant_nxt = pick ? 2'b10 : 2'b01;
                    last_nxt  = pick;
                end
            end
            REQ: begin
                if (g_st && bus.tx_rdy) begin
                    nxt  = g_end ? GAP : XFER;
                    done = g_end;
                end else if (!g_req) begin
                    nxt       = IDLE;
                    grant_nxt = 2'b00;
                end
            end
            XFER: begin
                if (g_end) begin
                    nxt  = GAP;
                    done = 1'b1;
                end
            end
            GAP: begin
                nxt       = IDLE;
                grant_nxt = 2'b00;
            end
            default: begin
                nxt       = IDLE;
                grant_nxt = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk_125) begin
        if (!sys_rst_n) begin
            cur      <= IDLE;
            grant    <= 2'b00;
            last     <= 1'b1;
            pkt_cnt0 <= 16'h0000;
            pkt_cnt1 <= 16'h0000;
        end else begin
            cur   <= nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
            if (done && grant[0]) pkt_cnt0 <= pkt_cnt0 + 16'd1;
            if (done && grant[1]) pkt_cnt1 <= pkt_cnt1 + 16'd1;
        end
    end

    assign busy  = (cur != IDLE);
    assign state = cur;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: a round-robin and a fixed-priority instance share one stimulus stream
// and are compared every cycle against a packet-level model of who owns the core.
module tb_tx_arbiter;

  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_XFER = 2;
  localparam int PH_GAP  = 3;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  st;
  logic [1:0]  en;
  logic [15:0] dat [2];
  logic        rdy;

  logic [1:0]  grant_o [2];
  logic        busy_o  [2];
  logic [15:0] cnt0_o  [2];
  logic [15:0] cnt1_o  [2];
  logic [1:0]  state_o [2];
  logic [20:0] bus_o   [2];

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 0;
  bit log_en = 0;
  int bad_rdy = 0;

  // model: owner of the core (-1 = nobody), packet phase, last winner, packets per requester
  int          m_owner [2] = '{-1, -1};
  int          m_phase [2] = '{0, 0};
  int          m_last  [2] = '{1, 1};
  logic [15:0] m_cnt   [2][2];

  logic [1:0] got_a[$];
  logic [1:0] got_b[$];
  logic [1:0] exp_q[$];
  logic [1:0] prev_g [2];

  tx_arbiter_if if_a ();
  tx_arbiter_if if_b ();

  assign if_a.r0_tx_req  = req[0];
  assign if_a.r0_tx_st   = st[0];
  assign if_a.r0_tx_end  = en[0];
  assign if_a.r0_tx_data = dat[0];
  assign if_a.r1_tx_req  = req[1];
  assign if_a.r1_tx_st   = st[1];
  assign if_a.r1_tx_end  = en[1];
  assign if_a.r1_tx_data = dat[1];
  assign if_a.tx_rdy     = rdy;
  assign if_b.r0_tx_req  = req[0];
  assign if_b.r0_tx_st   = st[0];
  assign if_b.r0_tx_end  = en[0];
  assign if_b.r0_tx_data = dat[0];
  assign if_b.r1_tx_req  = req[1];
  assign if_b.r1_tx_st   = st[1];
  assign if_b.r1_tx_end  = en[1];
  assign if_b.r1_tx_data = dat[1];
  assign if_b.tx_rdy     = rdy;

  assign bus_o[0] = {if_a.tx_req, if_a.tx_st, if_a.tx_end, if_a.r0_tx_rdy, if_a.r1_tx_rdy, if_a.tx_data};
  assign bus_o[1] = {if_b.tx_req, if_b.tx_st, if_b.tx_end, if_b.r0_tx_rdy, if_b.r1_tx_rdy, if_b.tx_data};

  tx_arbiter #(.PRIO0(1'b0)) dut_a (
    .clk_125(clk), .sys_rst_n(rst_n), .bus(if_a),
    .grant(grant_o[0]), .busy(busy_o[0]), .pkt_cnt0(cnt0_o[0]), .pkt_cnt1(cnt1_o[0]), .state(state_o[0])
  );

  tx_arbiter #(.PRIO0(1'b1)) dut_b (
    .clk_125(clk), .sys_rst_n(rst_n), .bus(if_b),
    .grant(grant_o[1]), .busy(busy_o[1]), .pkt_cnt0(cnt0_o[1]), .pkt_cnt1(cnt1_o[1]), .state(state_o[1])
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model, advanced on each rising edge from the inputs held over the previous cycle
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int o;
      int w;
      o = m_owner[d];
      if (!rst_n) begin
        m_owner[d] = -1;
        m_phase[d] = PH_IDLE;
        m_last[d]  = 1;
        m_cnt[d][0] = 16'h0000;
        m_cnt[d][1] = 16'h0000;
      end else begin
        case (m_phase[d])
          PH_IDLE: begin
            if (req != 2'b00) begin
              // instance 1 is the fixed-priority one
              if (req == 2'b11) w = (d == 1) ? 0 : 1 - m_last[d];
              else w = req[0] ? 0 : 1;
              m_owner[d] = w;
              m_last[d]  = w;
              m_phase[d] = PH_REQ;
            end
          end
          PH_REQ: begin
            if (st[o] && rdy) begin
              if (en[o]) begin
                m_phase[d] = PH_GAP;
                m_cnt[d][o] = m_cnt[d][o] + 16'd1;
              end else begin
                m_phase[d] = PH_XFER;
              end
            end else if (!req[o]) begin
              m_phase[d] = PH_IDLE;
              m_owner[d] = -1;
            end
          end
          PH_XFER: begin
            if (en[o]) begin
              m_phase[d] = PH_GAP;
              m_cnt[d][o] = m_cnt[d][o] + 16'd1;
            end
          end
          default: begin
            m_phase[d] = PH_IDLE;
            m_owner[d] = -1;
          end
        endcase
      end
    end
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        int o;
        bit act;
        logic [20:0] e_bus;
        logic [1:0]  e_grant;
        string tag;
        o = m_owner[d];
        tag = (d == 0) ? "a" : "b";
        act = (m_phase[d] == PH_REQ || m_phase[d] == PH_XFER) && (o >= 0);
        e_grant = (o < 0) ? 2'b00 : ((o == 0) ? 2'b01 : 2'b10);
        e_bus = {act ? req[o] : 1'b0, act ? st[o] : 1'b0, act ? en[o] : 1'b0,
                 (o == 0) ? rdy : 1'b0, (o == 1) ? rdy : 1'b0, act ? dat[o] : 16'h0000};
        check({tag, ".bus"},   32'(bus_o[d]),   32'(e_bus));
        check({tag, ".grant"}, 32'(grant_o[d]), 32'(e_grant));
        check({tag, ".busy"},  32'(busy_o[d]),  32'(m_phase[d] != PH_IDLE));
        check({tag, ".state"}, 32'(state_o[d]), 32'(m_phase[d]));
        check({tag, ".cnt0"},  32'(cnt0_o[d]),  32'(m_cnt[d][0]));
        check({tag, ".cnt1"},  32'(cnt1_o[d]),  32'(m_cnt[d][1]));
      end
    end
  end

  // grant-sequence recorder
  always @(negedge clk) begin
    if (log_en) begin
      if (grant_o[0] != 2'b00 && prev_g[0] == 2'b00) got_a.push_back(grant_o[0]);
      if (grant_o[1] != 2'b00 && prev_g[1] == 2'b00) got_b.push_back(grant_o[1]);
      if (grant_o[0] == 2'b01 && if_a.r1_tx_rdy) bad_rdy++;
    end
    prev_g[0] = grant_o[0];
    prev_g[1] = grant_o[1];
  end

  task automatic check_seq(input string name, input int which);
    int n;
    n = (which == 0) ? got_a.size() : got_b.size();
    check({name, ".len"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check($sformatf("%s.g%0d", name, i), 32'((which == 0) ? got_a[i] : got_b[i]), 32'(exp_q[i]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // driver: requester k sends one TLP of len beats, pacing itself on instance `which`
  task automatic send(input int k, input int which, input int len, input logic [15:0] base,
                      input bit keep, output int waited);
    int t;
    bit tmo;
    tmo = 0;
    waited = 0;
    req[k] = 1'b1;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!(state_o[which] == 2'd1 && grant_o[which][k]) && waited < 300);
    if (waited >= 300) tmo = 1;
    if (!tmo) begin
      st[k] = 1'b1;
      en[k] = (len == 1);
      dat[k] = base;
      #1;
      check($sformatf("r%0d.first_data", k), 32'((which == 0) ? if_a.tx_data : if_b.tx_data), 32'(base));
      t = 0;
      do begin
        @(posedge clk); #1;
        t++;
      end while (state_o[which] == 2'd1 && t < 300);
      if (t >= 300) tmo = 1;
      for (int i = 1; i < len && !tmo; i++) begin
        st[k] = 1'b0;
        en[k] = (i == len - 1);
        dat[k] = base + 16'(i);
        #1;
        check($sformatf("r%0d.data", k), 32'((which == 0) ? if_a.tx_data : if_b.tx_data), 32'(base + 16'(i)));
        @(posedge clk); #1;
      end
    end
    st[k] = 1'b0;
    en[k] = 1'b0;
    dat[k] = 16'h0000;
    if (!keep) req[k] = 1'b0;
    check($sformatf("r%0d.timeout", k), 32'(tmo), 32'd0);
  endtask

  initial begin
    int w;
    int c1;
    rst_n = 1'b0;
    req = 2'b00;
    st = 2'b00;
    en = 2'b00;
    dat[0] = 16'h0000;
    dat[1] = 16'h0000;
    rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1;
    for (int d = 0; d < 2; d++) begin
      check("rst.grant", 32'(grant_o[d]), 32'd0);
      check("rst.busy",  32'(busy_o[d]),  32'd0);
      check("rst.cnt0",  32'(cnt0_o[d]),  32'd0);
      check("rst.cnt1",  32'(cnt1_o[d]),  32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single 6-beat TLP from r0
    send(0, 0, 6, 16'h1000, 0, w);
    check("r0.grant_latency", 32'(w), 32'd1);
    check("r0.cnt_after", 32'(cnt0_o[0]), 32'd1);
    check("r0.gap_state", 32'(state_o[0]), 32'd3);
    @(posedge clk); #1;
    check("r0.idle_state", 32'(state_o[0]), 32'd0);
    check("r0.idle_grant", 32'(grant_o[0]), 32'd0);

    // both requesting continuously, round-robin instance
    do_reset();
    got_a.delete();
    got_b.delete();
    bad_rdy = 0;
    log_en = 1;
    fork
      begin
        int w0;
        for (int i = 0; i < 4; i++) send(0, 0, 3, 16'(32'h2000 + i * 16), 1, w0);
        req[0] = 1'b0;
      end
      begin
        int w1;
        for (int i = 0; i < 4; i++) send(1, 0, 3, 16'(32'h2800 + i * 16), 1, w1);
        req[1] = 1'b0;
      end
    join
    log_en = 0;
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    check_seq("rr_seq", 0);
    check("rr.cnt0", 32'(cnt0_o[0]), 32'd4);
    check("rr.cnt1", 32'(cnt1_o[0]), 32'd4);
    check("rr.r1_rdy_while_r0", 32'(bad_rdy), 32'd0);

    // both requesting, fixed-priority instance
    do_reset();
    got_a.delete();
    got_b.delete();
    log_en = 1;
    fork
      begin
        int w0;
        for (int i = 0; i < 3; i++) send(0, 1, 3, 16'(32'h3000 + i * 16), 1, w0);
        req[0] = 1'b0;
      end
      begin
        int w1;
        req[1] = 1'b1;
        send(1, 1, 2, 16'h3800, 0, w1);
      end
    join
    log_en = 0;
    exp_q = '{2'b01, 2'b01, 2'b01, 2'b10};
    check_seq("prio_seq", 1);

    // core stalls tx_rdy for 20 cycles after the request
    do_reset();
    rdy = 1'b0;
    fork
      begin
        int w0;
        send(0, 0, 4, 16'h4000, 0, w0);
      end
      begin
        repeat (20) begin
          @(posedge clk); #1;
          check("stall.state", 32'(state_o[0]), 32'd1);
          check("stall.tx_req", 32'(if_a.tx_req), 32'd1);
        end
        rdy = 1'b1;
      end
    join
    check("stall.cnt0", 32'(cnt0_o[0]), 32'd1);
    @(posedge clk); #1;

    // r1 withdraws its request before starting, r0 pending
    req[1] = 1'b1;
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (!(state_o[0] == 2'd1 && grant_o[0] == 2'b10) && w < 50);
    check("wd.r1_granted", 32'(grant_o[0]), 32'd2);
    c1 = int'(cnt1_o[0]);
    req = 2'b01;
    @(posedge clk); #1;
    check("wd.idle_state", 32'(state_o[0]), 32'd0);
    check("wd.idle_grant", 32'(grant_o[0]), 32'd0);
    @(posedge clk); #1;
    check("wd.r0_next", 32'(grant_o[0]), 32'd1);
    check("wd.cnt1_same", 32'(cnt1_o[0]), 32'(c1));
    send(0, 0, 2, 16'h4800, 0, w);

    // reset in the third XFER cycle
    req[0] = 1'b1;
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (!(state_o[0] == 2'd1 && grant_o[0] == 2'b01) && w < 50);
    st[0] = 1'b1;
    dat[0] = 16'h5000;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      st[0] = 1'b0;
      dat[0] = 16'h5000 + 16'(i);
    end
    check("rmid.in_xfer", 32'(state_o[0]), 32'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rmid.bus",   32'(bus_o[0]),   32'd0);
    check("rmid.grant", 32'(grant_o[0]), 32'd0);
    check("rmid.busy",  32'(busy_o[0]),  32'd0);
    check("rmid.cnt0",  32'(cnt0_o[0]),  32'd0);
    check("rmid.cnt1",  32'(cnt1_o[0]),  32'd0);
    dat[0] = 16'h0000;
    req = 2'b11;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rmid.tie_a", 32'(grant_o[0]), 32'd1);
    check("rmid.tie_b", 32'(grant_o[1]), 32'd1);
    req = 2'b00;
    @(posedge clk); #1;

    // random traffic, model-checked every cycle
    for (int i = 0; i < 800; i++) begin
      req[0] = ($urandom_range(0, 9) < 7);
      req[1] = ($urandom_range(0, 9) < 7);
      st = 2'($urandom_range(0, 3));
      en = 2'($urandom_range(0, 3));
      dat[0] = 16'($urandom);
      dat[1] = 16'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 63) != 0);
      @(posedge clk); #1;
    end
    req = 2'b00;
    st = 2'b00;
    en = 2'b00;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter PRIO0, default 0, meaning: 0 = round-robin, 1 = requester 0 always wins simultaneous requests.
REQ-002 clk_125  input  1  PCIe core user clock; all logic on its rising edge.
REQ-003 sys_rst_n  input  1  reset, synchronous, active-low.
REQ-004 r0_tx_req / r1_tx_req  input  1 each  requester wants to send one TLP.
REQ-005 r0_tx_rdy / r1_tx_rdy  output  1 each  per-requester copy of core tx_rdy.
REQ-006 r0_tx_st, r0_tx_end / r1_tx_st, r1_tx_end  input  1 each  first and last data cycle of a requester's TLP.
REQ-007 r0_tx_data / r1_tx_data  input  16 each  requester TLP data.
REQ-008 tx_req  output  1  to core tx_req_vc0.
REQ-009 tx_rdy  input  1  from core tx_rdy_vc0.
REQ-010 tx_st, tx_end  output  1 each  to core tx_st_vc0 / tx_end_vc0.
REQ-011 tx_data  output  16  to core tx_data_vc0.
REQ-012 grant  output  2  one-hot current owner; 2'b00 when none.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 pkt_cnt0 / pkt_cnt1  output  16 each  TLPs completed per requester.

Function
REQ-015 FSM states: IDLE, REQ, XFER, GAP; state, grant, last-grant pointer and counters are registered.
REQ-016 IDLE: with no request, stay IDLE; with any request, register grant and go to REQ on the next edge (1-cycle arbitration latency).
REQ-017 If only one requester is active, that requester is granted.
REQ-018 If both are active and PRIO0=0, the requester not recorded in the last-grant pointer is granted.
REQ-019 If both are active and PRIO0=1, requester 0 is granted.
REQ-020 Last-grant pointer updates to the granted requester on the IDLE->REQ transition only.
REQ-021 tx_req = granted requester's tx_req while in REQ or XFER; 0 in IDLE and GAP.
REQ-022 Granted requester's rx_tx_rdy = core tx_rdy (combinational); the non-granted requester's tx_rdy is always 0.
REQ-023 tx_st, tx_end and tx_data are combinationally muxed from the granted requester in REQ and XFER, and forced to 0 in IDLE and GAP.
REQ-024 REQ -> XFER on the cycle the granted requester's tx_st is high while tx_rdy is high.
REQ-025 REQ -> IDLE, with grant cleared, if the granted requester drops tx_req before tx_st (withdrawal); no counter increments.
REQ-026 XFER -> GAP on the cycle the granted tx_end is high; the granted pkt_cntN increments by 1, wrapping 16'hFFFF -> 0.
REQ-027 tx_st and tx_end high in the same cycle in REQ goes directly REQ -> GAP and counts one packet.
REQ-028 In XFER, loss of the requester's tx_req or core tx_rdy does not abort the packet; only tx_end ends it.
REQ-029 GAP lasts exactly 1 cycle; grant clears to 00 and the FSM returns to IDLE, giving a minimum 2-cycle gap between TLPs (re-arbitration).
REQ-030 A tx_st or tx_end from a non-granted requester is ignored and never reaches the core.

Reset
REQ-031 On a clock edge with sys_rst_n=0: state=IDLE, grant=00, busy=0, pkt_cnt0=pkt_cnt1=0, and last-grant pointer=requester 1 (so requester 0 wins the first tie).
REQ-032 Reset asserted mid-packet takes effect at the next edge; tx_req, tx_st, tx_end and tx_data are 0 from that edge, and the partial packet is not counted.

Verification
REQ-033 Reset, then r0 only sends a 6-cycle TLP (data 16'h1000..1005): grant=01 one cycle after r0_tx_req; tx_data matches cycle-for-cycle; pkt_cnt0=1; then GAP and IDLE.
REQ-034 PRIO0=0, r0 and r1 request together continuously, 4 packets each: grant sequence 01,10,01,10,...; pkt_cnt0=pkt_cnt1=4; r1 sees tx_rdy=0 while r0 is granted.
REQ-035 PRIO0=1, both request continuously: only r0 is granted until r0 drops its request, then r1 is granted.
REQ-036 Core holds tx_rdy=0 for 20 cycles after tx_req: FSM stays in REQ with tx_req=1; the transfer proceeds after tx_rdy rises.
REQ-037 Granted r1 drops tx_req in REQ before tx_st: return to IDLE, pkt_cnt1 unchanged, and pending r0 granted next.
REQ-038 Assert sys_rst_n=0 in XFER cycle 3: the next edge gives all outputs 0 and counters 0; after release, the first tie goes to r0.
